// File: rtl/hms_timer_bank.sv
// Multi-channel hour/min/sec/centisecond timer bank sharing one tick prescaler.
// Each channel is an hms_timer_ch instance; reads go through a channel-select mux.

module hms_timer_ch #(
  parameter int HOUR_MAX = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_tick,
  input  logic        i_run_stop,
  input  logic        i_clear,
  input  logic        i_mode,
  input  logic        i_stop_at_zero,
  input  logic        i_adj_up,
  input  logic        i_adj_dn,
  input  logic [1:0]  i_adj_field,
  input  logic        i_lap,
  output logic [23:0] o_time,
  output logic [23:0] o_lap,
  output logic        o_running,
  output logic        o_done
);
  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [6:0] cs;
  } hms_t;

  localparam logic [4:0] HR_TOP = 5'(HOUR_MAX - 1);

  hms_t r_time, r_lap, w_nt, w_nl, w_dec;
  logic r_running, r_done, w_nr, w_nd;

  function automatic hms_t f_up(input hms_t t);
    hms_t n = t;
    if (t.cs != 7'd99) n.cs = t.cs + 7'd1;
    else begin
      n.cs = '0;
      if (t.sc != 6'd59) n.sc = t.sc + 6'd1;
      else begin
        n.sc = '0;
        if (t.mn != 6'd59) n.mn = t.mn + 6'd1;
        else begin
          n.mn = '0;
          n.hr = (t.hr == HR_TOP) ? 5'd0 : t.hr + 5'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic hms_t f_dn(input hms_t t);
    hms_t n = t;
    if (t.cs != 7'd0) n.cs = t.cs - 7'd1;
    else begin
      n.cs = 7'd99;
      if (t.sc != 6'd0) n.sc = t.sc - 6'd1;
      else begin
        n.sc = 6'd59;
        if (t.mn != 6'd0) n.mn = t.mn - 6'd1;
        else begin
          n.mn = 6'd59;
          n.hr = (t.hr == 5'd0) ? HR_TOP : t.hr - 5'd1;
        end
      end
    end
    return n;
  endfunction

  // Field adjust wraps inside the field only; neighbours never see a carry.
  function automatic hms_t f_adj(input hms_t t, input logic [1:0] fld, input logic up);
    hms_t n = t;
    unique case (fld)
      2'd0: n.cs = up ? ((t.cs == 7'd99) ? 7'd0 : t.cs + 7'd1)
                      : ((t.cs == 7'd0) ? 7'd99 : t.cs - 7'd1);
      2'd1: n.sc = up ? ((t.sc == 6'd59) ? 6'd0 : t.sc + 6'd1)
                      : ((t.sc == 6'd0) ? 6'd59 : t.sc - 6'd1);
      2'd2: n.mn = up ? ((t.mn == 6'd59) ? 6'd0 : t.mn + 6'd1)
                      : ((t.mn == 6'd0) ? 6'd59 : t.mn - 6'd1);
      default: n.hr = up ? ((t.hr == HR_TOP) ? 5'd0 : t.hr + 5'd1)
                         : ((t.hr == 5'd0) ? HR_TOP : t.hr - 5'd1);
    endcase
    return n;
  endfunction

  always_comb begin
    w_nt  = r_time;
    w_nl  = r_lap;
    w_nr  = r_running;
    w_nd  = r_done;
    w_dec = f_dn(r_time);
    if (i_clear) begin
      w_nt = '0;
      w_nl = '0;
      w_nr = 1'b0;
      w_nd = 1'b0;
    end else begin
      if (i_lap) w_nl = r_time;
      if (i_adj_up || i_adj_dn) begin
        w_nt = f_adj(r_time, i_adj_field, i_adj_up);
      end else begin
        // Tick uses the pre-toggle run state, so a stop on a tick still counts.
        if (r_running && i_tick) begin
          if (!i_mode) w_nt = f_up(r_time);
          else if (!i_stop_at_zero) w_nt = w_dec;
          else if (r_time == '0 || w_dec == '0) begin
            w_nt = '0;
            w_nr = 1'b0;
            w_nd = 1'b1;
          end else w_nt = w_dec;
        end
        if (i_run_stop) begin
          w_nr = ~r_running;
          if (!r_running) w_nd = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time    <= '0;
      r_lap     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_time    <= w_nt;
      r_lap     <= w_nl;
      r_running <= w_nr;
      r_done    <= w_nd;
    end
  end

  assign o_time    = r_time;
  assign o_lap     = r_lap;
  assign o_running = r_running;
  assign o_done    = r_done;
endmodule

module hms_timer_bank #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int N_CH     = 2,
  parameter int HOUR_MAX = 24,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_run_stop,
  input  logic [N_CH-1:0] i_clear,
  input  logic [N_CH-1:0] i_mode,
  input  logic [N_CH-1:0] i_stop_at_zero,
  input  logic [N_CH-1:0] i_adj_up,
  input  logic [N_CH-1:0] i_adj_dn,
  input  logic [1:0]      i_adj_field,
  input  logic [N_CH-1:0] i_lap,
  input  logic [CH_W-1:0] i_rd_sel,
  output logic [23:0]     o_time,
  output logic [23:0]     o_lap,
  output logic [N_CH-1:0] o_running,
  output logic [N_CH-1:0] o_done,
  output logic            o_tick
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]          r_div;
  logic                      r_tick;
  logic [N_CH-1:0][23:0]     w_time;
  logic [N_CH-1:0][23:0]     w_lap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_TOP);
      r_div  <= (r_div == DIV_TOP) ? '0 : r_div + DIV_W'(1);
    end
  end

  assign o_tick = r_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    hms_timer_ch #(.HOUR_MAX(HOUR_MAX)) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_tick        (r_tick),
      .i_run_stop    (i_run_stop[g]),
      .i_clear       (i_clear[g]),
      .i_mode        (i_mode[g]),
      .i_stop_at_zero(i_stop_at_zero[g]),
      .i_adj_up      (i_adj_up[g]),
      .i_adj_dn      (i_adj_dn[g]),
      .i_adj_field   (i_adj_field),
      .i_lap         (i_lap[g]),
      .o_time        (w_time[g]),
      .o_lap         (w_lap[g]),
      .o_running     (o_running[g]),
      .o_done        (o_done[g])
    );
  end

  // Unmatched select leaves the defaults, so out-of-range channels read as 0.
  always_comb begin
    o_time = '0;
    o_lap  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (i_rd_sel == CH_W'(c)) begin
        o_time = w_time[c];
        o_lap  = w_lap[c];
      end
    end
  end
endmodule

// File: tb/tb_hms_timer_bank.sv
// Directed bench for hms_timer_bank: stimulus pushes expectations, a negedge monitor pops and compares.

module tb_hms_timer_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  i_run_stop, i_clear, i_mode, i_stop_at_zero, i_adj_up, i_adj_dn, i_lap;
  logic [1:0]  i_adj_field;
  logic [0:0]  i_rd_sel;
  logic [23:0] o_time, o_lap;
  logic [1:0]  o_running, o_done;
  logic        o_tick;

  typedef struct packed {
    logic [4:0]  mask;  // {tick, done, run, lap, time}
    logic [23:0] tm;
    logic [23:0] lp;
    logic [1:0]  run;
    logic [1:0]  dn;
    logic        tk;
  } exp_t;

  exp_t  q_exp[$];
  string q_nm[$];
  logic  req = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;

  hms_timer_bank #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(2), .HOUR_MAX(24)) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
    .i_mode(i_mode), .i_stop_at_zero(i_stop_at_zero), .i_adj_up(i_adj_up),
    .i_adj_dn(i_adj_dn), .i_adj_field(i_adj_field), .i_lap(i_lap),
    .i_rd_sel(i_rd_sel), .o_time(o_time), .o_lap(o_lap),
    .o_running(o_running), .o_done(o_done), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  // Monitor: compares whatever the stimulus queued against the selected outputs.
  always @(negedge clk) begin
    if (req) begin
      exp_t  e;
      string nm;
      logic  bad;
      n_chk++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e   = q_exp.pop_front();
        nm  = q_nm.pop_front();
        bad = 1'b0;
        if (e.mask[0] && o_time    !== e.tm)  bad = 1'b1;
        if (e.mask[1] && o_lap     !== e.lp)  bad = 1'b1;
        if (e.mask[2] && o_running !== e.run) bad = 1'b1;
        if (e.mask[3] && o_done    !== e.dn)  bad = 1'b1;
        if (e.mask[4] && o_tick    !== e.tk)  bad = 1'b1;
        if (bad) begin
          n_fail++;
          $display("FAIL %s: got time=%h lap=%h run=%b done=%b tick=%b, want time=%h lap=%h run=%b done=%b tick=%b (mask %b)",
                   nm, o_time, o_lap, o_running, o_done, o_tick, e.tm, e.lp, e.run, e.dn, e.tk, e.mask);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic sel, input logic [4:0] mask,
                     input logic [23:0] tm, input logic [23:0] lp,
                     input logic [1:0] run, input logic [1:0] dn, input logic tk);
    exp_t e;
    e.mask = mask; e.tm = tm; e.lp = lp; e.run = run; e.dn = dn; e.tk = tk;
    i_rd_sel = sel;
    q_exp.push_back(e);
    q_nm.push_back(nm);
    req = 1'b1;
    @(negedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] rs, input logic [1:0] clr, input logic [1:0] up,
                       input logic [1:0] dn, input logic [1:0] lap);
    i_run_stop = rs; i_clear = clr; i_adj_up = up; i_adj_dn = dn; i_lap = lap;
    step();
    i_run_stop = '0; i_clear = '0; i_adj_up = '0; i_adj_dn = '0; i_lap = '0;
  endtask

  // Park so the next edge does not carry a tick.
  task automatic avoid_tick();
    if (o_tick) step();
  endtask

  // Stop just before an edge that carries a tick.
  task automatic sync_tick();
    int n = 0;
    while (!o_tick && n < 30) begin
      step();
      n++;
    end
    if (!o_tick) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_timeout: got no o_tick within 30 cycles, want one every 10");
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      sync_tick();
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    i_run_stop = '0; i_clear = '0; i_mode = '0; i_stop_at_zero = '0;
    i_adj_up = '0; i_adj_dn = '0; i_adj_field = '0; i_lap = '0; i_rd_sel = '0;
    repeat (3) step();
    chk("reset_state", 1'b0, 5'b11111, '0, '0, 2'b00, 2'b00, 1'b0);
    chk("reset_state_ch1", 1'b1, 5'b00011, '0, '0, 2'b00, 2'b00, 1'b0);

    // Prescaler: first tick after 10 edges, then every 10.
    step();
    reset = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      chk($sformatf("prescaler_k%0d", k), 1'b0, 5'b11101, '0, '0, 2'b00, 2'b00,
          (k == 10 || k == 20));
      step();
    end

    // Up wrap from 23:59:59:99.
    for (int f = 0; f < 4; f++) begin
      i_adj_field = 2'(f);
      pulse('0, '0, '0, 2'b01, '0);
    end
    chk("adj_dn_all_fields", 1'b0, 5'b01101, hms(23, 59, 59, 99), '0, 2'b00, 2'b00, 1'b0);
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    tick_n(1);
    chk("up_wrap", 1'b0, 5'b01101, hms(0, 0, 0, 0), '0, 2'b01, 2'b00, 1'b0);
    avoid_tick();
    pulse('0, 2'b01, '0, '0, '0);
    chk("clear_ch0", 1'b0, 5'b01111, '0, '0, 2'b00, 2'b00, 1'b0);

    // Countdown to zero with stop_at_zero.
    i_adj_field = 2'd1;
    pulse('0, '0, 2'b01, '0, '0);
    pulse('0, '0, 2'b01, '0, '0);
    chk("set_2s", 1'b0, 5'b00001, hms(0, 0, 2, 0), '0, 2'b00, 2'b00, 1'b0);
    i_mode = 2'b01; i_stop_at_zero = 2'b01;
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    tick_n(199);
    chk("cd_199", 1'b0, 5'b01101, hms(0, 0, 0, 1), '0, 2'b01, 2'b00, 1'b0);
    tick_n(1);
    chk("cd_expire", 1'b0, 5'b01101, '0, '0, 2'b00, 2'b01, 1'b0);
    tick_n(10);
    chk("cd_hold_zero", 1'b0, 5'b01101, '0, '0, 2'b00, 2'b01, 1'b0);
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    chk("rerun_clears_done", 1'b0, 5'b01101, '0, '0, 2'b01, 2'b00, 1'b0);
    tick_n(1);
    chk("re_expire", 1'b0, 5'b01101, '0, '0, 2'b00, 2'b01, 1'b0);

    // Down wrap on ch1.
    i_mode = 2'b11; i_stop_at_zero = 2'b01;
    avoid_tick();
    pulse(2'b10, '0, '0, '0, '0);
    tick_n(1);
    chk("down_wrap_ch1", 1'b1, 5'b01101, hms(23, 59, 59, 99), '0, 2'b10, 2'b01, 1'b0);
    avoid_tick();
    pulse('0, 2'b11, '0, '0, '0);
    chk("clear_both", 1'b1, 5'b01111, '0, '0, 2'b00, 2'b00, 1'b0);

    // Lap and channel isolation.
    i_mode = 2'b00; i_stop_at_zero = 2'b00;
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    tick_n(37);
    avoid_tick();
    pulse('0, '0, '0, '0, 2'b01);
    chk("lap_capture", 1'b0, 5'b00111, hms(0, 0, 0, 37), hms(0, 0, 0, 37), 2'b01, 2'b00, 1'b0);
    tick_n(1);
    chk("lap_keeps_counting", 1'b0, 5'b00011, hms(0, 0, 0, 38), hms(0, 0, 0, 37), 2'b01, 2'b00, 1'b0);
    chk("ch1_isolated", 1'b1, 5'b01111, '0, '0, 2'b01, 2'b00, 1'b0);

    // Simultaneous events.
    avoid_tick();
    pulse(2'b01, 2'b01, '0, '0, '0);
    chk("clear_beats_run", 1'b0, 5'b01111, '0, '0, 2'b00, 2'b00, 1'b0);
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    i_adj_field = 2'd2;
    sync_tick();
    pulse('0, '0, 2'b01, '0, '0);
    chk("adj_drops_tick", 1'b0, 5'b01101, hms(0, 1, 0, 0), '0, 2'b01, 2'b00, 1'b0);
    tick_n(1);
    chk("tick_after_adj", 1'b0, 5'b00101, hms(0, 1, 0, 1), '0, 2'b01, 2'b00, 1'b0);
    sync_tick();
    pulse(2'b01, '0, '0, '0, '0);
    chk("stop_on_tick_counts", 1'b0, 5'b00101, hms(0, 1, 0, 2), '0, 2'b00, 2'b00, 1'b0);

    // Reset mid-run.
    avoid_tick();
    pulse(2'b01, '0, '0, '0, '0);
    tick_n(3);
    chk("run_before_reset", 1'b0, 5'b00101, hms(0, 1, 0, 5), '0, 2'b01, 2'b00, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("reset_mid_run", 1'b0, 5'b11111, '0, '0, 2'b00, 2'b00, 1'b0);
    step();
    reset = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 9 || k == 10)
        chk($sformatf("tick_after_rerelease_k%0d", k), 1'b0, 5'b10001, '0, '0, 2'b00, 2'b00, (k == 10));
      else
        step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
